// File: rtl/wb_cmd_master.sv
// wb_cmd_master: bridges a valid/ready command/response channel onto a
// Wishbone B4 pipelined master port, one transaction at a time, with an
// issue-to-ack timeout that aborts a transaction and reports an error.
module wb_cmd_master #(
  parameter logic [31:0] TIMEOUT = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  // command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  // Wishbone master
  output logic [31:0] wb_addr,
  output logic [31:0] wb_data_w,
  output logic        wb_we,
  output logic        wb_stb,
  output logic        wb_cyc,
  input  logic [31:0] wb_data_r,
  input  logic        wb_ack,
  input  logic        wb_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] tmo_cnt_r;
  logic        tmo_hit_s;

  // The counter is zero on the first REQ cycle, so reaching TIMEOUT-1
  // means TIMEOUT cycles have been spent with wb_cyc high.
  assign tmo_hit_s = (tmo_cnt_r == (TIMEOUT - 32'd1));

  // Transaction FSM; every output is a register updated alongside the state
  // so the ports never glitch and cmd_ready/wb_cyc/rsp_valid are exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      tmo_cnt_r <= 32'd0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
      wb_addr   <= 32'd0;
      wb_data_w <= 32'd0;
      wb_we     <= 1'b0;
      wb_stb    <= 1'b0;
      wb_cyc    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          // cmd_ready is only ever high in IDLE, so it doubles as the
          // acceptance qualifier; right after reset it comes up one cycle late.
          if (cmd_valid && cmd_ready) begin
            wb_addr   <= cmd_addr;
            wb_data_w <= cmd_data;
            wb_we     <= cmd_we;
            wb_cyc    <= 1'b1;
            wb_stb    <= 1'b1;
            tmo_cnt_r <= 32'd0;
            cmd_ready <= 1'b0;
            state_r   <= REQ;
          end else begin
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end
        end

        REQ: begin
          // Acks are not meaningful before the strobe is taken, so only the
          // timeout and the stall input steer this state.
          if (tmo_hit_s) begin
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= 32'd0;
            state_r   <= RESP;
          end else if (!wb_stall) begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
            wb_stb    <= 1'b0;
            state_r   <= WAIT;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
            state_r   <= REQ;
          end
        end

        WAIT: begin
          // An ack arriving on the expiry cycle still wins over the timeout.
          if (wb_ack) begin
            wb_cyc    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= wb_we ? 32'd0 : wb_data_r;
            state_r   <= RESP;
          end else if (tmo_hit_s) begin
            wb_cyc    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= 32'd0;
            state_r   <= RESP;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
            state_r   <= WAIT;
          end
        end

        RESP: begin
          // Response fields hold until consumed; the next command can be
          // accepted one cycle after the handshake at the earliest.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r   <= RESP;
          end
        end

        default: begin
          state_r   <= IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
          wb_cyc    <= 1'b0;
          wb_stb    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: each transaction is described by a few numbers
// (stall length, ack delay, response back-pressure); expected port values for
// every cycle are derived from that description by simple arithmetic.
module tb_wb_cmd_master;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] wb_addr, wb_data_w, wb_data_r;
  logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_stall;

  int checks   = 0;
  int failures = 0;

  // phase 0: no model checking, 1: idle, 2: transaction in flight
  int          phase = 0;
  int          k     = 0;
  logic        m_we;
  logic [31:0] m_addr, m_data, m_rdata;
  int          m_s, m_d, m_h;
  logic        m_err;

  // measured per transaction, compared against hand-computed literals
  int          cnt_stb, cnt_cyc, cnt_rv, first_rv;
  logic [31:0] cap_rdata, stb_wdata;
  logic        cap_err, stb_we;

  wb_cmd_master #(.TIMEOUT(32'd8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .wb_addr(wb_addr), .wb_data_w(wb_data_w), .wb_we(wb_we), .wb_stb(wb_stb),
    .wb_cyc(wb_cyc), .wb_data_r(wb_data_r), .wb_ack(wb_ack), .wb_stall(wb_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the transaction description.
  always @(negedge clk) begin
    int   stb_end;
    logic e_stb, e_cyc, e_rv;
    if (phase == 1) begin
      chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      chk("idle_wb_cyc",    {31'd0, wb_cyc},    32'd0);
      chk("idle_wb_stb",    {31'd0, wb_stb},    32'd0);
      chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end else if (phase == 2) begin
      stb_end = (m_s + 1 < T) ? m_s + 1 : T;
      e_stb = (k >= 1) && (k <= stb_end);
      e_cyc = (k >= 1) && (k <= m_d);
      e_rv  = (k >= m_d + 1) && (k <= m_d + 1 + m_h);
      chk("wb_stb",    {31'd0, wb_stb},    {31'd0, e_stb});
      chk("wb_cyc",    {31'd0, wb_cyc},    {31'd0, e_cyc});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, e_rv});
      chk("cmd_ready", {31'd0, cmd_ready}, 32'd0);
      if (e_cyc) begin
        chk("wb_addr",   wb_addr,   m_addr);
        chk("wb_data_w", wb_data_w, m_data);
        chk("wb_we",     {31'd0, wb_we}, {31'd0, m_we});
      end
      if (e_rv) begin
        chk("rsp_err",  {31'd0, rsp_err}, {31'd0, m_err});
        chk("rsp_data", rsp_data, (m_we || m_err) ? 32'd0 : m_rdata);
      end
      if (wb_stb) begin
        cnt_stb++;
        stb_wdata = wb_data_w;
        stb_we    = wb_we;
      end
      if (wb_cyc) cnt_cyc++;
      if (rsp_valid) begin
        cnt_rv++;
        cap_rdata = rsp_data;
        cap_err   = rsp_err;
        if (first_rv < 0) first_rv = k;
      end
    end
  end

  // One transaction: s stall cycles, ack a cycles into WAIT (unless noack),
  // rsp_ready held low h cycles; spur adds acks where they must be ignored.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input int s, input int a,
                         input bit noack, input int h, input bit spur);
    bit real_ack;
    m_we = we; m_addr = addr; m_data = data; m_rdata = rdata;
    m_s = s; m_h = h;
    if (!noack && (s + 2 + a <= T)) begin
      m_d = s + 2 + a; m_err = 1'b0;
    end else begin
      m_d = T; m_err = 1'b1;
    end
    cnt_stb = 0; cnt_cyc = 0; cnt_rv = 0; first_rv = -1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_data = data;
    wb_ack = spur; wb_data_r = 32'hBAD0_0000;
    @(posedge clk); #1;
    phase = 2; k = 1;
    cmd_valid = 1'b0; cmd_addr = ~addr; cmd_data = ~data; cmd_we = ~we;
    while (k <= m_d + 1 + h) begin
      real_ack  = !noack && (k == s + 2 + a);
      wb_stall  = (k <= s);
      wb_ack    = real_ack || (spur && (k == 1 || k == m_d + 1));
      wb_data_r = real_ack ? rdata : (32'hBAD0_0000 | k);
      rsp_ready = (k == m_d + 1 + h) || (spur && k <= m_d);
      @(posedge clk); #1;
      k++;
    end
    phase = 1;
    wb_ack = 1'b0; wb_stall = 1'b0; rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'd0; cmd_data = 32'd0;
    rsp_ready = 1'b0; wb_data_r = 32'd0; wb_ack = 1'b0; wb_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_wb_cyc",    {31'd0, wb_cyc},    32'd0);
    chk("rst_wb_stb",    {31'd0, wb_stb},    32'd0);
    chk("rst_wb_we",     {31'd0, wb_we},     32'd0);
    chk("rst_wb_addr",   wb_addr,   32'd0);
    chk("rst_wb_data_w", wb_data_w, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_rsp_data",  rsp_data,  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    phase = 1;
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    // write 5 to address 0, ack one cycle after the strobe
    run_txn(1'b1, 32'd0, 32'd5, 32'hFFFF_FFFF, 0, 0, 1'b0, 0, 1'b0);
    chk("wr_stb_cycles", cnt_stb, 32'd1);
    chk("wr_rsp_latency", first_rv, 32'd3);
    chk("wr_stb_data", stb_wdata, 32'd5);
    chk("wr_stb_we", {31'd0, stb_we}, 32'd1);
    chk("wr_rsp_data", cap_rdata, 32'd0);

    // read with four stall cycles, data 0xE
    run_txn(1'b0, 32'h0000_0100, 32'd0, 32'h0000_000E, 4, 0, 1'b0, 0, 1'b0);
    chk("stall_stb_cycles", cnt_stb, 32'd5);
    chk("stall_rsp_data", cap_rdata, 32'h0000_000E);
    chk("stall_rsp_err", {31'd0, cap_err}, 32'd0);

    // read that is never acked
    run_txn(1'b0, 32'h0000_0200, 32'd0, 32'd0, 0, 0, 1'b1, 0, 1'b0);
    chk("tmo_cyc_cycles", cnt_cyc, 32'd8);
    chk("tmo_rsp_err", {31'd0, cap_err}, 32'd1);
    chk("tmo_rsp_data", cap_rdata, 32'd0);

    // back-pressured response, with acks in REQ, RESP and IDLE to ignore
    run_txn(1'b0, 32'h0000_0300, 32'd0, 32'hA5A5_1234, 1, 1, 1'b0, 5, 1'b1);
    chk("hold_rv_cycles", cnt_rv, 32'd6);
    chk("hold_rsp_data", cap_rdata, 32'hA5A5_1234);

    // ack on the very expiry cycle wins
    run_txn(1'b0, 32'h0000_0304, 32'd0, 32'h1234_5678, 0, 6, 1'b0, 0, 1'b0);
    chk("edge_rsp_err", {31'd0, cap_err}, 32'd0);
    chk("edge_rsp_data", cap_rdata, 32'h1234_5678);

    // ack one cycle too late lands in RESP and is ignored
    run_txn(1'b0, 32'h0000_0308, 32'd0, 32'h0BAD_BEEF, 0, 7, 1'b0, 1, 1'b0);
    chk("late_rsp_err", {31'd0, cap_err}, 32'd1);

    // timeout while still stalled in REQ
    run_txn(1'b1, 32'h0000_0400, 32'hCAFE_0001, 32'd0, 7, 0, 1'b0, 0, 1'b0);
    chk("stall_tmo_stb", cnt_stb, 32'd8);
    chk("stall_tmo_err", {31'd0, cap_err}, 32'd1);

    // reset while waiting for ack; a late ack must produce nothing
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h0000_0500;
    @(posedge clk); #1;
    phase = 0;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("wait_wb_cyc", {31'd0, wb_cyc}, 32'd1);
    chk("wait_wb_stb", {31'd0, wb_stb}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_wb_cyc", {31'd0, wb_cyc}, 32'd0);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    wb_ack = 1'b1; wb_data_r = 32'h0000_0777;
    @(posedge clk); #1;
    wb_ack = 1'b0;
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rel_wb_cyc", {31'd0, wb_cyc}, 32'd0);
    phase = 1;
    repeat (3) @(posedge clk);
    #1;

    // normal operation resumes
    run_txn(1'b0, 32'h0000_0600, 32'd0, 32'h5555_AAAA, 2, 2, 1'b0, 2, 1'b0);
    chk("resume_rsp_data", cap_rdata, 32'h5555_AAAA);
    repeat (2) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 32'd1024, giving the maximum cycles from transaction issue to ack before abort.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-003 The block SHALL have port rst, input, 1, the reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1, command offered.
REQ-005 The block SHALL have port cmd_ready, output, 1, command accepted when cmd_valid && cmd_ready.
REQ-006 The block SHALL have port cmd_we, input, 1, 1 = write, 0 = read.
REQ-007 The block SHALL have ports cmd_addr and cmd_data, input, 32 each, transaction address and write data.
REQ-008 The block SHALL have port rsp_valid, output, 1, response available.
REQ-009 The block SHALL have port rsp_ready, input, 1, response consumed when rsp_valid && rsp_ready.
REQ-010 The block SHALL have port rsp_data, output, 32, read data (0 for writes and errors).
REQ-011 The block SHALL have port rsp_err, output, 1, the transaction timed out.
REQ-012 The block SHALL have Wishbone B4 pipelined master ports wb_addr (out, 32), wb_data_w (out, 32), wb_we (out, 1), wb_stb (out, 1), wb_cyc (out, 1), wb_data_r (in, 32), wb_ack (in, 1) and wb_stall (in, 1).

Function
REQ-013 The block SHALL implement the states IDLE, REQ, WAIT and RESP, with at most one Wishbone transaction outstanding.
REQ-014 cmd_ready SHALL be 1 only in IDLE; a command accepted in IDLE SHALL register cmd_addr, cmd_data and cmd_we into wb_addr, wb_data_w and wb_we, and the next state SHALL be REQ.
REQ-015 In REQ, wb_cyc and wb_stb SHALL be 1; the block SHALL stay in REQ while wb_stall=1, and on a cycle with wb_stall=0 it SHALL go to WAIT.
REQ-016 In WAIT, wb_cyc SHALL be 1 and wb_stb SHALL be 0; on wb_ack=1 the block SHALL capture rsp_data (wb_data_r if read, else 0), set rsp_err=0, and go to RESP.
REQ-017 wb_ack SHALL be ignored in IDLE, REQ and RESP; an ack in those states SHALL cause no state change.
REQ-018 A timeout counter SHALL clear on command acceptance and increment every cycle in REQ or WAIT; when it reaches TIMEOUT-1 with no ack that cycle, the block SHALL go to RESP with rsp_err=1 and rsp_data=0.
REQ-019 wb_ack in the same cycle as timeout expiry SHALL take priority, giving a normal response with rsp_err=0.
REQ-020 In RESP, rsp_valid SHALL be 1 and wb_cyc, wb_stb SHALL be 0; rsp_valid, rsp_data and rsp_err SHALL be held stable until rsp_ready=1, then the next state SHALL be IDLE.
REQ-021 wb_cyc SHALL be 0 in IDLE and RESP, so that it falls the cycle after ack or timeout.
REQ-022 wb_stb=1 SHALL imply wb_cyc=1.
REQ-023 wb_addr, wb_data_w and wb_we SHALL stay constant from acceptance until leaving WAIT.
REQ-024 Minimum latency SHALL be: command accepted cycle N, wb_stb high N+1, ack N+2 at earliest, rsp_valid N+3.
REQ-025 A new command SHALL be accepted no earlier than the cycle after the response handshake.

Reset
REQ-026 While rst=1, the block SHALL drive state=IDLE, wb_cyc=0, wb_stb=0, wb_we=0, wb_addr=0, wb_data_w=0, rsp_valid=0, rsp_err=0, rsp_data=0, timeout counter=0 and cmd_ready=0.
REQ-027 Reset asserted mid-transaction (REQ, WAIT or RESP) SHALL abandon it with no response, and wb_cyc SHALL be 0 the cycle after rst is sampled.
REQ-028 On the first cycle after rst deasserts, cmd_ready SHALL be 1.

Verification
REQ-029 Write addr=0, data=5 to a slave with stall=0 and ack 1 cycle after stb -> one stb cycle with wb_we=1, wb_data_w=5; rsp_valid 3 cycles after acceptance; rsp_err=0, rsp_data=0.
REQ-030 Read, with slave holding wb_stall=1 for 4 cycles then ack returning data 32'h0000_000E -> wb_stb high 5 cycles, address stable, rsp_data=32'hE, rsp_err=0.
REQ-031 Read with no ack ever and TIMEOUT=8 -> wb_cyc high exactly 8 cycles, then rsp_valid=1, rsp_err=1, rsp_data=0, wb_cyc=0.
REQ-032 Hold rsp_ready=0 for 5 cycles after a response -> rsp_valid/rsp_data/rsp_err stable, cmd_ready=0, wb_cyc=0 throughout; IDLE follows the handshake.
REQ-033 Assert rst for 1 cycle while in WAIT -> next cycle wb_cyc=0, rsp_valid=0, cmd_ready=1 after release; a late wb_ack then produces no response.
REQ-034 Formal checks SHALL hold: wb_stb implies wb_cyc; at most 1 outstanding transaction; rsp_valid and wb_cyc never both 1.
